// File: rtl/hsv_pkg.sv
// Shared types and constants for the HSV -> RGB555 pixel regenerator.
package hsv_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CHROMA,
        SCALE,
        ASSEMBLE
    } state_t;

    localparam int HUE_SECTOR = 16;
    localparam int HUE_MAX    = 96;

    localparam int R_OFS = 10;
    localparam int G_OFS = 5;
    localparam int B_OFS = 0;

    function automatic logic [15:0] pack_rgb555(input logic [4:0] r,
                                                input logic [4:0] g,
                                                input logic [4:0] b);
        logic [15:0] w;
        w            = '0;
        w[R_OFS +: 5] = r;
        w[G_OFS +: 5] = g;
        w[B_OFS +: 5] = b;
        return w;
    endfunction

endpackage

// File: rtl/serial_mult5.sv
// 5x5 -> 10-bit unsigned shift-add multiplier; the start edge consumes bit 0,
// four further edges consume bits 1..4, so a product is ready 5 edges after start.
module serial_mult5 (
    input  logic       clk,
    input  logic       res,
    input  logic       start,
    input  logic [4:0] a,
    input  logic [4:0] b,
    output logic [9:0] product,
    output logic       ready
);

    logic [9:0] acc_q, acc_d;
    logic [9:0] mcand_q, mcand_d;
    logic [3:0] mplier_q, mplier_d;
    logic [2:0] cnt_q, cnt_d;

    always_comb begin
        // NOTE: every variable gets a default first, so no path can infer a latch.
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        if (start) begin
            acc_d    = b[0] ? {5'd0, a} : 10'd0;
            mcand_d  = {4'd0, a, 1'b0};
            mplier_d = b[4:1];
            cnt_d    = 3'd4;
        end else if (cnt_q != 3'd0) begin
            if (mplier_q[0]) begin
                acc_d = acc_q + mcand_q;
            end
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q - 3'd1;
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
        end else begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
        end
    end

    assign product = acc_q;
    assign ready   = (cnt_q == 3'd0);

endmodule

// File: rtl/hsv2rgb.sv
// HSV (7/5/5) -> RGB555 converter with read/done handshake, 12 cycles per pixel.
// Optional HSV2RGB_FASTGRAY_EN: zero-saturation pixels skip straight to ASSEMBLE.
module hsv2rgb
    import hsv_pkg::*;
(
    input  logic        clk,
    input  logic        res,
    input  logic        read,
    input  logic [6:0]  hue,
    input  logic [4:0]  saturation,
    input  logic [4:0]  value,
    input  logic        hue_invalid,
    output logic [15:0] data,
    output logic        busy,
    output logic        done
);

    state_t      state_q, state_d;
    logic [2:0]  sector_q;
    logic [3:0]  frac_q;
    logic [4:0]  val_q;
    logic [4:0]  c_q;
    logic [4:0]  d_q;
    logic [15:0] data_q;
    logic        done_q;

    logic [6:0]  hue_wrap;
    logic [4:0]  sat_eff;
    logic        accept;
    logic        mul_start;
    logic [4:0]  mul_a;
    logic [4:0]  mul_b;
    logic [9:0]  product;
    logic        mul_ready;
    logic [9:0]  c_sum;
    logic [9:0]  d_sum;
    logic [4:0]  c_calc;
    logic [4:0]  d_calc;
    logic [4:0]  mn, rise, fall;
    logic [15:0] rgb;

    assign hue_wrap = (hue >= 7'(HUE_MAX)) ? hue - 7'(HUE_MAX) : hue;
    assign sat_eff  = hue_invalid ? 5'd0 : saturation;
    assign accept   = (state_q == IDLE) && read;

    // The first product takes its operands straight from the ports on the accept edge.
    assign mul_start = accept || ((state_q == CHROMA) && mul_ready);
    assign mul_a     = (state_q == CHROMA) ? c_calc : value;
    assign mul_b     = (state_q == CHROMA) ? {1'b0, frac_q} : sat_eff;

    serial_mult5 u_mult (
        .clk     (clk),
        .res     (res),
        .start   (mul_start),
        .a       (mul_a),
        .b       (mul_b),
        .product (product),
        .ready   (mul_ready)
    );

    // Rounded m/31 and k/16; the sums never exceed 1007 and 473 respectively.
    assign c_sum  = product + {5'd0, product[9:5]} + 10'd16;
    assign c_calc = 5'(c_sum >> 5);
    assign d_sum  = product + 10'd8;
    assign d_calc = 5'(d_sum >> 4);

    assign mn   = val_q - c_q;
    assign rise = mn + d_q;
    assign fall = val_q - d_q;

    always_comb begin
        rgb = pack_rgb555(val_q, mn, fall);
        case (sector_q)
            3'd0:    rgb = pack_rgb555(val_q, rise, mn);
            3'd1:    rgb = pack_rgb555(fall, val_q, mn);
            3'd2:    rgb = pack_rgb555(mn, val_q, rise);
            3'd3:    rgb = pack_rgb555(mn, fall, val_q);
            3'd4:    rgb = pack_rgb555(rise, mn, val_q);
            default: rgb = pack_rgb555(val_q, mn, fall);
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (read) begin
`ifdef HSV2RGB_FASTGRAY_EN
                    state_d = (sat_eff == 5'd0) ? ASSEMBLE : CHROMA;
`else
                    state_d = CHROMA;
`endif
                end
            end
            CHROMA:   if (mul_ready) state_d = SCALE;
            SCALE:    if (mul_ready) state_d = ASSEMBLE;
            default:  state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            state_q  <= IDLE;
            sector_q <= '0;
            frac_q   <= '0;
            val_q    <= '0;
            c_q      <= '0;
            d_q      <= '0;
            data_q   <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= (state_q == ASSEMBLE);
            if (accept) begin
                sector_q <= hue_wrap[6:4];
                frac_q   <= hue_wrap[3:0];
                val_q    <= value;
                c_q      <= '0;
                d_q      <= '0;
            end
            if ((state_q == CHROMA) && mul_ready) c_q <= c_calc;
            if ((state_q == SCALE) && mul_ready) d_q <= d_calc;
            if (state_q == ASSEMBLE) data_q <= rgb;
        end
    end

    assign data = data_q;
    assign busy = (state_q != IDLE);
    assign done = done_q;

endmodule

// File: tb/tb_hsv2rgb.sv
// Self-checking bench for hsv2rgb: directed table, random pixels against a
// behavioural model, and handshake/reset sequences.
module tb_hsv2rgb;

    logic        clk = 1'b0;
    logic        res = 1'b0;
    logic        read = 1'b0;
    logic [6:0]  hue = '0;
    logic [4:0]  saturation = '0;
    logic [4:0]  value = '0;
    logic        hue_invalid = 1'b0;
    logic [15:0] data;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    hsv2rgb dut (
        .clk         (clk),
        .res         (res),
        .read        (read),
        .hue         (hue),
        .saturation  (saturation),
        .value       (value),
        .hue_invalid (hue_invalid),
        .data        (data),
        .busy        (busy),
        .done        (done)
    );

    typedef struct {
        logic [6:0]  h;
        logic [4:0]  s;
        logic [4:0]  v;
        logic        inv;
        logic [15:0] exp;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: hue circle split into six 16-code sectors, RGB levels from rounded arithmetic.
    function automatic logic [15:0] model(input int h, input int s, input int v, input bit inv);
        int hh, sec, f, m, c, d, lo, up, dn;
        int lvl_r[6], lvl_g[6], lvl_b[6];
        hh  = (h >= 96) ? h - 96 : h;
        if (inv) s = 0;
        sec = hh / 16;
        f   = hh % 16;
        m   = v * s;
        c   = (m + m / 32 + 16) / 32;
        d   = (c * f + 8) / 16;
        lo  = v - c;
        up  = lo + d;
        dn  = v - d;
        lvl_r = '{v,  dn, lo, lo, up, v };
        lvl_g = '{up, v,  v,  dn, lo, lo};
        lvl_b = '{lo, lo, up, v,  v,  dn};
        return 16'((lvl_r[sec] << 10) | (lvl_g[sec] << 5) | lvl_b[sec]);
    endfunction

    function automatic int exp_latency(input logic [4:0] s, input logic inv);
`ifdef HSV2RGB_FASTGRAY_EN
        return (inv || s == 5'd0) ? 1 : 11;
`else
        return 11;
`endif
    endfunction

    // One full transaction: accept at E0, scramble inputs, optionally poke read mid-flight.
    task automatic do_pixel(input logic [6:0] h, input logic [4:0] s, input logic [4:0] v,
                            input logic inv, input logic [15:0] exp, input string name,
                            input bit poke);
        int          lat;
        bit          got;
        bit          stable;
        logic [15:0] prev;
        @(negedge clk);
        hue = h; saturation = s; value = v; hue_invalid = inv; read = 1'b1;
        prev = data;
        @(posedge clk);
        #1;
        check({name, "_busy_accept"}, busy, 1'b1);
        @(negedge clk);
        read = 1'b0;
        hue = 7'($urandom); saturation = 5'($urandom); value = 5'($urandom);
        hue_invalid = 1'($urandom);
        lat = 0; got = 1'b0; stable = 1'b1;
        for (int n = 1; n <= 40 && !got; n++) begin
            @(posedge clk);
            #1;
            if (done) begin
                got = 1'b1;
                lat = n;
            end else if (data !== prev) begin
                stable = 1'b0;
            end
            if (poke && n == 2) read = 1'b1;
            if (poke && n == 6) read = 1'b0;
        end
        read = 1'b0;
        check({name, "_latency"}, lat, exp_latency(s, inv));
        check({name, "_data"}, data, exp);
        check({name, "_stable"}, stable, 1'b1);
        @(posedge clk);
        #1;
        check({name, "_done_pulse"}, done, 1'b0);
        check({name, "_busy_after"}, busy, 1'b0);
    endtask

    vec_t vecs[9];

    initial begin
        int          lat;
        bit          got;
        logic [6:0]  rh;
        logic [4:0]  rs, rv;
        logic        ri;

        vecs[0] = '{7'd0,   5'd31, 5'd31, 1'b0, 16'h7C00};
        vecs[1] = '{7'd8,   5'd31, 5'd31, 1'b0, 16'h7E00};
        vecs[2] = '{7'd24,  5'd16, 5'd16, 1'b0, 16'h3208};
        vecs[3] = '{7'd100, 5'd31, 5'd31, 1'b0, 16'h7D00};
        vecs[4] = '{7'd17,  5'd0,  5'd20, 1'b0, 16'h5294};
        vecs[5] = '{7'd77,  5'd31, 5'd20, 1'b1, 16'h5294};
        vecs[6] = '{7'd32,  5'd31, 5'd31, 1'b0, 16'h03E0};
        vecs[7] = '{7'd95,  5'd31, 5'd31, 1'b0, 16'h7C02};
        vecs[8] = '{7'd127, 5'd31, 5'd31, 1'b0, 16'h0BE0};

        #2;
        check("reset_data", data, 16'h0000);
        check("reset_busy", busy, 1'b0);
        check("reset_done", done, 1'b0);
        @(negedge clk);
        res = 1'b1;

        for (int i = 0; i < 9; i++) begin
            do_pixel(vecs[i].h, vecs[i].s, vecs[i].v, vecs[i].inv, vecs[i].exp,
                     $sformatf("vec%0d", i), 1'b0);
        end

        // read held high through a transaction: ignored while busy, accepted at E12.
        @(negedge clk);
        hue = 7'd40; saturation = 5'd25; value = 5'd30; hue_invalid = 1'b0; read = 1'b1;
        @(posedge clk);
        @(negedge clk);
        hue = 7'd70; saturation = 5'd12; value = 5'd19;
        got = 1'b0;
        for (int n = 1; n <= 40 && !got; n++) begin
            @(posedge clk);
            #1;
            if (done) got = 1'b1;
        end
        check("b2b_first_done", got, 1'b1);
        check("b2b_first_data", data, model(40, 25, 30, 1'b0));
        @(posedge clk);
        #1;
        check("b2b_accept_e12", busy, 1'b1);
        read = 1'b0;
        lat = 0; got = 1'b0;
        for (int n = 1; n <= 40 && !got; n++) begin
            @(posedge clk);
            #1;
            if (done) begin got = 1'b1; lat = n; end
        end
        check("b2b_second_latency", lat, 11);
        check("b2b_second_data", data, model(70, 12, 19, 1'b0));

        // Mid-transaction read pokes must not disturb the result.
        do_pixel(7'd50, 5'd20, 5'd27, 1'b0, model(50, 20, 27, 1'b0), "poke", 1'b1);

        // Reset during SCALE aborts the pixel with no done pulse.
        @(negedge clk);
        hue = 7'd32; saturation = 5'd31; value = 5'd31; hue_invalid = 1'b0; read = 1'b1;
        @(posedge clk);
        @(negedge clk);
        read = 1'b0;
        repeat (7) @(posedge clk);
        @(negedge clk);
        res = 1'b0;
        #1;
        check("abort_busy", busy, 1'b0);
        check("abort_data", data, 16'h0000);
        check("abort_done", done, 1'b0);
        @(negedge clk);
        res = 1'b1;
        got = 1'b0;
        for (int n = 0; n < 15; n++) begin
            @(posedge clk);
            #1;
            if (done) got = 1'b1;
        end
        check("abort_no_done", got, 1'b0);
        do_pixel(7'd32, 5'd31, 5'd31, 1'b0, 16'h03E0, "after_abort", 1'b0);

        for (int i = 0; i < 40; i++) begin
            rh = 7'($urandom);
            rs = (i % 8 == 0) ? 5'd0 : 5'($urandom);
            rv = 5'($urandom);
            ri = ($urandom_range(0, 9) == 0);
            do_pixel(rh, rs, rv, ri, model(rh, rs, rv, ri), $sformatf("rand%0d", i), i[0]);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
